// File: rtl/min_stream_sel.sv
// Streaming minimum selector: tracks the smallest-distance candidate of each frame
// and holds {d, index, payload, count} until the downstream stage accepts it.
module min_stream_sel #(
    parameter int unsigned D_W      = 11,
    parameter int unsigned W_W      = 24,
    parameter int unsigned N        = 8,
    parameter int unsigned IDX_W    = $clog2(N),
    parameter int unsigned CNT_W    = $clog2(N + 1),
    parameter int unsigned TIE_HIGH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [D_W-1:0]   d_in,
    input  logic [W_W-1:0]   w_in,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [D_W-1:0]   d_min,
    output logic [IDX_W-1:0] d_min_index,
    output logic [W_W-1:0]   w_min,
    output logic [CNT_W-1:0] out_cnt
);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [D_W-1:0]   best_d_q, best_d_d;
    logic [W_W-1:0]   best_w_q, best_w_d;
    logic [IDX_W-1:0] best_i_q, best_i_d;

    logic             in_ready_d;
    logic             out_valid_d;
    logic [D_W-1:0]   d_min_d;
    logic [IDX_W-1:0] d_min_index_d;
    logic [W_W-1:0]   w_min_d;
    logic [CNT_W-1:0] out_cnt_d;

    logic             accept;
    logic             take;
    logic             frame_end;
    logic [D_W-1:0]   win_d;
    logic [W_W-1:0]   win_w;
    logic [IDX_W-1:0] win_i;

    // Winner including the current beat; index 0 always seeds the running best.
    always_comb begin
        accept    = in_valid & in_ready;
        take      = (cnt_q == '0) || (d_in < best_d_q) ||
                    ((TIE_HIGH != 0) && (d_in == best_d_q));
        win_d     = take ? d_in  : best_d_q;
        win_w     = take ? w_in  : best_w_q;
        win_i     = take ? cnt_q : best_i_q;
        frame_end = accept && (in_last || (cnt_q == LAST_IDX));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        best_d_d      = best_d_q;
        best_w_d      = best_w_q;
        best_i_d      = best_i_q;
        in_ready_d    = in_ready;
        out_valid_d   = out_valid;
        d_min_d       = d_min;
        d_min_index_d = d_min_index;
        w_min_d       = w_min;
        out_cnt_d     = out_cnt;

        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    best_d_d = win_d;
                    best_w_d = win_w;
                    best_i_d = win_i;
                    if (frame_end) begin
                        state_d       = ST_HOLD;
                        cnt_d         = '0;
                        in_ready_d    = 1'b0;
                        out_valid_d   = 1'b1;
                        d_min_d       = win_d;
                        d_min_index_d = win_i;
                        w_min_d       = win_w;
                        out_cnt_d     = CNT_W'(cnt_q) + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Hand-off cycle never overlaps a new accept.
                if (out_ready) begin
                    state_d     = ST_ACC;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_ACC;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            best_d_q    <= '0;
            best_w_q    <= '0;
            best_i_q    <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            d_min       <= '0;
            d_min_index <= '0;
            w_min       <= '0;
            out_cnt     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_d_q    <= best_d_d;
            best_w_q    <= best_w_d;
            best_i_q    <= best_i_d;
            in_ready    <= in_ready_d;
            out_valid   <= out_valid_d;
            d_min       <= d_min_d;
            d_min_index <= d_min_index_d;
            w_min       <= w_min_d;
            out_cnt     <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_min_stream_sel.sv
// Bench for min_stream_sel: both tie policies side by side on shared stimulus,
// directed cases plus random frames checked cycle by cycle against a frame-level model.
module tb_min_stream_sel;

    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [10:0] d_in;
    logic [23:0] w_in;
    logic        in_last;
    logic        out_ready;

    logic        rdy_hi, rdy_lo, ov_hi, ov_lo;
    logic [10:0] dmin_hi, dmin_lo;
    logic [2:0]  idx_hi, idx_lo;
    logic [23:0] wmin_hi, wmin_lo;
    logic [3:0]  cnt_hi, cnt_lo;

    int checks   = 0;
    int failures = 0;
    bit rnd_or   = 1'b0;

    always #5 clk = ~clk;

    min_stream_sel #(.TIE_HIGH(1)) dut_hi (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_hi),
        .d_in(d_in), .w_in(w_in), .in_last(in_last),
        .out_valid(ov_hi), .out_ready(out_ready),
        .d_min(dmin_hi), .d_min_index(idx_hi), .w_min(wmin_hi), .out_cnt(cnt_hi)
    );

    min_stream_sel #(.TIE_HIGH(0)) dut_lo (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_lo),
        .d_in(d_in), .w_in(w_in), .in_last(in_last),
        .out_valid(ov_lo), .out_ready(out_ready),
        .d_min(dmin_lo), .d_min_index(idx_lo), .w_min(wmin_lo), .out_cnt(cnt_lo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    int unsigned q_d[$];
    logic [23:0] q_w[$];
    bit          m_known = 1'b0;
    bit          m_hold;
    logic [10:0] e_d[2];
    logic [2:0]  e_i[2];
    logic [23:0] e_w[2];
    logic [3:0]  e_c;

    // Index 0 of the expectation arrays is the later-wins policy, 1 the earlier-wins.
    task automatic close_frame();
        int unsigned m = 32'hFFFF_FFFF;
        int first = -1;
        int last  = -1;
        foreach (q_d[k]) if (q_d[k] < m) m = q_d[k];
        foreach (q_d[k]) if (q_d[k] == m) begin
            if (first < 0) first = k;
            last = k;
        end
        e_d[0] = 11'(m);     e_d[1] = 11'(m);
        e_i[0] = 3'(last);   e_i[1] = 3'(first);
        e_w[0] = q_w[last];  e_w[1] = q_w[first];
        e_c    = 4'(q_d.size());
        q_d.delete();
        q_w.delete();
        m_hold = 1'b1;
    endtask

    // Compare the DUTs against the model, then advance the model with the
    // inputs that the coming rising edge will sample.
    always @(negedge clk) begin
        if (m_known) begin
            chk("rdy_hi",  32'(rdy_hi),  32'(!m_hold));
            chk("rdy_lo",  32'(rdy_lo),  32'(!m_hold));
            chk("ov_hi",   32'(ov_hi),   32'(m_hold));
            chk("ov_lo",   32'(ov_lo),   32'(m_hold));
            chk("dmin_hi", 32'(dmin_hi), 32'(e_d[0]));
            chk("dmin_lo", 32'(dmin_lo), 32'(e_d[1]));
            chk("idx_hi",  32'(idx_hi),  32'(e_i[0]));
            chk("idx_lo",  32'(idx_lo),  32'(e_i[1]));
            chk("wmin_hi", 32'(wmin_hi), 32'(e_w[0]));
            chk("wmin_lo", 32'(wmin_lo), 32'(e_w[1]));
            chk("cnt_hi",  32'(cnt_hi),  32'(e_c));
            chk("cnt_lo",  32'(cnt_lo),  32'(e_c));
        end
        if (rst) begin
            m_known = 1'b1;
            m_hold  = 1'b0;
            q_d.delete();
            q_w.delete();
            e_d[0] = '0; e_d[1] = '0;
            e_i[0] = '0; e_i[1] = '0;
            e_w[0] = '0; e_w[1] = '0;
            e_c    = '0;
        end else if (m_known) begin
            if (!m_hold) begin
                if (in_valid) begin
                    q_d.push_back(32'(d_in));
                    q_w.push_back(w_in);
                    if (in_last || q_d.size() == N) close_frame();
                end
            end else if (out_ready) begin
                m_hold = 1'b0;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_or) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_beat(input logic [10:0] d, input logic [23:0] w, input logic last);
        bit acc = 1'b0;
        int n   = 0;
        in_valid = 1'b1;
        d_in     = d;
        w_in     = w;
        in_last  = last;
        do begin
            @(negedge clk);
            acc = rdy_hi;
            step();
            n++;
        end while (!acc && n < 100);
        if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        d_in     = 11'($urandom_range(0, 2047));
        repeat (n) step();
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ov_hi && n < 50);
        if (!ov_hi) chk(tag, 32'(ov_hi), 32'd1);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] t1[8];
        t1 = '{11'd9, 11'd4, 11'd7, 11'd4, 11'd12, 11'd5, 11'd4, 11'd30};

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; d_in = '0; w_in = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ov",   32'(ov_hi),   32'd0);
        chk("reset_rdy",  32'(rdy_hi),  32'd1);
        chk("reset_dmin", 32'(dmin_hi), 32'd0);
        chk("reset_cnt",  32'(cnt_hi),  32'd0);
        step();

        // Full frame with three-way tie on d=4
        for (int k = 0; k < N; k++) send_beat(t1[k], 24'(100 + k), 1'b0);
        wait_result("t1_timeout");
        chk("t1_dmin_hi", 32'(dmin_hi), 32'd4);
        chk("t1_idx_hi",  32'(idx_hi),  32'd6);
        chk("t1_w_hi",    32'(wmin_hi), 32'd106);
        chk("t1_cnt_hi",  32'(cnt_hi),  32'd8);
        chk("t1_dmin_lo", 32'(dmin_lo), 32'd4);
        chk("t1_idx_lo",  32'(idx_lo),  32'd1);
        chk("t1_w_lo",    32'(wmin_lo), 32'd101);
        step();

        // Early frame end
        send_beat(11'd20, 24'd300, 1'b0);
        send_beat(11'd3,  24'd301, 1'b0);
        send_beat(11'd15, 24'd302, 1'b1);
        @(negedge clk);
        chk("t3_latency", 32'(ov_hi),   32'd1);
        chk("t3_dmin",    32'(dmin_hi), 32'd3);
        chk("t3_idx",     32'(idx_hi),  32'd1);
        chk("t3_cnt",     32'(cnt_hi),  32'd3);
        step();

        // Back-pressure with a pending d=0 beat
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) send_beat(11'(50 + k), 24'(400 + k), 1'b0);
        in_valid = 1'b1; d_in = 11'd0; w_in = 24'd555; in_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_rdy",  32'(rdy_hi),  32'd0);
            chk("t4_ov",   32'(ov_hi),   32'd1);
            chk("t4_dmin", 32'(dmin_hi), 32'd50);
            chk("t4_w",    32'(wmin_hi), 32'd400);
        end
        step();
        out_ready = 1'b1;
        send_beat(11'd0, 24'd555, 1'b0);
        for (int k = 1; k < N; k++) send_beat(11'(100 + k), 24'(600 + k), 1'b0);
        wait_result("t4_timeout");
        chk("t4b_dmin", 32'(dmin_hi), 32'd0);
        chk("t4b_idx",  32'(idx_hi),  32'd0);
        chk("t4b_w",    32'(wmin_hi), 32'd555);
        chk("t4b_cnt",  32'(cnt_hi),  32'd8);
        step();

        // Reset mid-frame, then a frame of all-max distances
        for (int k = 0; k < 5; k++) send_beat(11'(k), 24'(700 + k), 1'b0);
        rst = 1'b1; in_valid = 1'b1; d_in = 11'd0; w_in = 24'd999;
        step();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t5_ov_after_rst", 32'(ov_hi),   32'd0);
        chk("t5_dmin_rst",     32'(dmin_hi), 32'd0);
        step();
        for (int k = 0; k < N; k++) send_beat(11'd2047, 24'(200 + k), 1'b0);
        wait_result("t5_timeout");
        chk("t5_dmin_hi", 32'(dmin_hi), 32'd2047);
        chk("t5_idx_hi",  32'(idx_hi),  32'd7);
        chk("t5_w_hi",    32'(wmin_hi), 32'd207);
        chk("t5_cnt_hi",  32'(cnt_hi),  32'd8);
        chk("t5_idx_lo",  32'(idx_lo),  32'd0);
        chk("t5_w_lo",    32'(wmin_lo), 32'd200);
        step();

        // Random frames with input gaps and random downstream back-pressure
        rnd_or = 1'b1;
        for (int f = 0; f < 1000; f++) begin
            int len = $urandom_range(1, N);
            for (int i = 0; i < len; i++) begin
                logic [10:0] d;
                logic        last;
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                d    = $urandom_range(0, 1) ? 11'($urandom_range(0, 7))
                                            : 11'($urandom_range(0, 2047));
                last = (i == len - 1) ? ((len == N) ? 1'($urandom_range(0, 1)) : 1'b1)
                                      : 1'b0;
                send_beat(d, 24'($urandom), last);
            end
        end
        rnd_or    = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
